gold_interaction_ctrl: RTL and testbench
========================================

Name: gold_interaction_ctrl

Overview:
Upstream of the gold mover. Watches the per-pixel draw stream for one frame and decides, once per frame, whether the gold bag is pushed, and in which direction. It also decides whether the bag may fall, whether the digger ate a crashed bag, and whether a falling bag crushed the digger. All decision outputs are registered and change only on startOfFrame, so the mover sees stable levels for a whole frame.

Parameters:
CELL_SIZE, 32, gold sprite width/height in pixels
DIRT_THRESH, 4, probe-row dirt pixel count at or below which the support is considered gone
PUSH_FRAMES, 2, consecutive frames of side overlap required before a push is issued
SCREEN_BOTTOM, 448, first Y row below the playfield; the bag cannot fall past it

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse at frame start; closes the previous frame's scan
pixelX  in  11  current scan X (signed)
pixelY  in  11  current scan Y (signed)
digger_draw_req  in  1  digger sprite pixel opaque at (pixelX,pixelY)
gold_draw_req  in  1  gold sprite pixel opaque at (pixelX,pixelY)
dirt_draw_req  in  1  dirt/background-map pixel is dirt at (pixelX,pixelY)
digger_topLeftX  in  11  digger position X (signed)
digger_topLeftY  in  11  digger position Y (signed)
gold_topLeftX  in  11  gold position X (signed), from the mover
gold_topLeftY  in  11  gold position Y (signed), from the mover
gold_state  in  4  mover status: 0 rest/moving, 1 falling, 2 crashed, 3 eaten
collision  out  1  push request, level held for one frame
side  out  1  push origin: 1 = digger on right, 0 = left; valid while collision=1
can_fall  out  1  support below the bag is gone, level for one frame
been_eaten  out  1  sticky; set once the digger overlaps a crashed bag
digger_killed  out  1  one-frame level; a falling bag overlapped the digger

Behaviour:
- Reset (asynchronous, reset=1): all outputs 0; all accumulators and counters cleared; FSM to WAIT_FRAME.
- FSM states:
  - WAIT_FRAME: ignores pixels; goes to SCAN on startOfFrame.
  - SCAN: accumulates the per-frame flags below; on startOfFrame goes to EVAL.
  - EVAL: lasts exactly 1 cycle; updates outputs, clears accumulators, then goes to SCAN.
- Latency: the results of frame N appear 2 cycles after the startOfFrame that ends frame N, and hold until the next EVAL.
- Accumulators in SCAN:
  - ovl: digger_draw_req & gold_draw_req in the same cycle.
  - dirt_cnt (6 bit, saturates at 32): counts dirt_draw_req when pixelY == gold_topLeftY+CELL_SIZE and gold_topLeftX <= pixelX <= gold_topLeftX+CELL_SIZE-1.
- A startOfFrame that arrives on the same cycle as a pixel event: the pixel belongs to the closing frame and is included.
- EVAL rules:
  - push_cnt (2 bit, saturating):
    - Increments when ovl, gold_state==0, and |digger_topLeftY - gold_topLeftY| < CELL_SIZE/2 (side approach).
    - Any other frame clears it.
  - collision = (push_cnt reaches PUSH_FRAMES this EVAL). After firing, push_cnt clears, so a held push re-fires every PUSH_FRAMES frames.
  - side = (digger_topLeftX > gold_topLeftX). Equal X gives 0.
  - can_fall = (gold_state==0) & (dirt_cnt <= DIRT_THRESH) & (gold_topLeftY+CELL_SIZE < SCREEN_BOTTOM).
  - When collision and can_fall both qualify in the same EVAL, collision wins and can_fall=0.
  - digger_killed = ovl & (gold_state==1).
  - been_eaten:
    - Set when ovl & (gold_state==2).
    - Stays set until reset.
    - When it is set, collision, can_fall and digger_killed are forced to 0.
- Arithmetic: sums are computed at 12 bits signed, so negative/off-screen positions never wrap into a false probe row.
- Reset asserted mid-frame: behaves as at power-up, and the partial frame is discarded.

Optional Feature:
GOLD_PUSH_BLOCK_EN
- Defined:
  - A second counter, side_dirt_cnt, counts dirt pixels in the column adjacent to the bag on the push side. For side=1 this is pixelX == gold_topLeftX-1; for side=0 it is pixelX == gold_topLeftX+CELL_SIZE. Both use rows gold_topLeftY..+CELL_SIZE-1.
  - The column is chosen from the current side-of-digger compare, and only counts pixels on the current frame's push side.
  - In EVAL, collision is suppressed and push_cnt is cleared if side_dirt_cnt > DIRT_THRESH.
- Not defined: no side probe; pushes are never blocked.

Test Plan:
- Pushes from the right:
  - Setup: gold at (64,160); digger at (90,160), overlapping 4 pixels each frame for 2 frames; dirt row below full (32).
  - Expected: collision=1 and side=1 for exactly frame 3; can_fall=0 throughout.
- Falls when support is gone:
  - Setup: gold at (64,160); row 192 has 3 dirt pixels in X 64..95; no overlap.
  - Expected: can_fall=1 from 2 cycles after the frame-closing startOfFrame, held one frame.
  - Repeat with 5 dirt pixels: can_fall stays 0.
- Bottom edge:
  - Setup: gold_topLeftY=416 (416+32=448), no dirt below.
  - Expected: can_fall=0.
- Crush and eat:
  - Setup: gold_state=1 with overlap.
  - Expected: digger_killed=1 for one frame.
  - Then with gold_state=2 and overlap: been_eaten=1 and stays 1 for 10 more frames without overlap. Later overlaps give collision=0.
- Reset mid-scan:
  - Setup: after 1 frame of overlap, assert reset for 3 cycles mid-frame, then 1 more overlap frame.
  - Expected: no collision; a push needs 2 fresh frames.
- Blocked push (with GOLD_PUSH_BLOCK_EN):
  - Setup: the push case above, with 20 dirt pixels at X=63.
  - Expected: collision stays 0. Without the macro, the same stimulus fires collision.

Source files
------------

// File: rtl/gold_interaction_ctrl.sv
// Per-frame gold bag interaction decisions (push, fall, eat, crush) from the pixel draw stream.
// Optional side-column push blocking is compiled in with `define GOLD_PUSH_BLOCK_EN.
module gold_interaction_ctrl #(
  parameter int CELL_SIZE     = 32,
  parameter int DIRT_THRESH   = 4,
  parameter int PUSH_FRAMES   = 2,
  parameter int SCREEN_BOTTOM = 448
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  input  logic               digger_draw_req,
  input  logic               gold_draw_req,
  input  logic               dirt_draw_req,
  input  logic signed [10:0] digger_topLeftX,
  input  logic signed [10:0] digger_topLeftY,
  input  logic signed [10:0] gold_topLeftX,
  input  logic signed [10:0] gold_topLeftY,
  input  logic        [3:0]  gold_state,
  output logic               collision,
  output logic               side,
  output logic               can_fall,
  output logic               been_eaten,
  output logic               digger_killed
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SCAN       = 2'd1,
    EVAL       = 2'd2
  } state_t;

  localparam logic signed [11:0] CELL_S   = 12'(CELL_SIZE);
  localparam logic signed [11:0] HALF_S   = 12'(CELL_SIZE / 2);
  localparam logic signed [11:0] BOTTOM_S = 12'(SCREEN_BOTTOM);
  localparam logic        [5:0]  THRESH   = 6'(DIRT_THRESH);
  localparam logic        [5:0]  DIRT_SAT = 6'd32;
  localparam logic        [1:0]  PUSH_N   = 2'(PUSH_FRAMES);

  state_t      state_q, state_d;
  logic        ovl_q, ovl_d;
  logic [5:0]  dirt_cnt_q, dirt_cnt_d;
  logic [1:0]  push_cnt_q, push_cnt_d;
  logic        collision_q, collision_d;
  logic        side_q, side_d;
  logic        can_fall_q, can_fall_d;
  logic        been_eaten_q, been_eaten_d;
  logic        digger_killed_q, digger_killed_d;

  // All geometry is widened to 12 bits so edge positions cannot wrap into the probe row.
  logic signed [11:0] px_s, py_s, dig_x_s, dig_y_s, gold_x_s, gold_y_s;
  logic signed [11:0] probe_y_s, probe_x_hi_s, dy_s, dy_abs_s;

  assign px_s     = {pixelX[10], pixelX};
  assign py_s     = {pixelY[10], pixelY};
  assign dig_x_s  = {digger_topLeftX[10], digger_topLeftX};
  assign dig_y_s  = {digger_topLeftY[10], digger_topLeftY};
  assign gold_x_s = {gold_topLeftX[10], gold_topLeftX};
  assign gold_y_s = {gold_topLeftY[10], gold_topLeftY};

  assign probe_y_s    = gold_y_s + CELL_S;
  assign probe_x_hi_s = gold_x_s + CELL_S - 12'sd1;
  assign dy_s         = dig_y_s - gold_y_s;
  assign dy_abs_s     = (dy_s < 12'sd0) ? -dy_s : dy_s;

  logic digger_right, in_probe, bottom_ok;
  logic gs_rest, gs_fall, gs_crash;

  assign digger_right = dig_x_s > gold_x_s;
  assign in_probe     = (py_s == probe_y_s) && (px_s >= gold_x_s) && (px_s <= probe_x_hi_s);
  assign bottom_ok    = probe_y_s < BOTTOM_S;
  assign gs_rest      = gold_state == 4'd0;
  assign gs_fall      = gold_state == 4'd1;
  assign gs_crash     = gold_state == 4'd2;

  logic       approach, push_block, push_fire, eaten_nxt;
  logic [1:0] push_inc;

`ifdef GOLD_PUSH_BLOCK_EN
  logic [5:0]         side_dirt_cnt_q, side_dirt_cnt_d;
  logic signed [11:0] side_col_x_s;
  logic               in_side;

  // The probed column follows whichever side the digger is on right now.
  assign side_col_x_s = digger_right ? (gold_x_s - 12'sd1) : (gold_x_s + CELL_S);
  assign in_side      = (px_s == side_col_x_s) && (py_s >= gold_y_s) && (py_s <= probe_y_s - 12'sd1);
  assign push_block   = side_dirt_cnt_q > THRESH;
`else
  assign push_block   = 1'b0;
`endif

  assign approach  = ovl_q && gs_rest && (dy_abs_s < HALF_S);
  assign push_inc  = (push_cnt_q == 2'd3) ? 2'd3 : push_cnt_q + 2'd1;
  assign push_fire = approach && (push_inc >= PUSH_N) && !push_block;
  assign eaten_nxt = been_eaten_q | (ovl_q & gs_crash);

  always_comb begin
    state_d         = state_q;
    ovl_d           = ovl_q;
    dirt_cnt_d      = dirt_cnt_q;
    push_cnt_d      = push_cnt_q;
    collision_d     = collision_q;
    side_d          = side_q;
    can_fall_d      = can_fall_q;
    been_eaten_d    = been_eaten_q;
    digger_killed_d = digger_killed_q;
`ifdef GOLD_PUSH_BLOCK_EN
    side_dirt_cnt_d = side_dirt_cnt_q;
`endif
    case (state_q)
      WAIT_FRAME: begin
        if (startOfFrame) state_d = SCAN;
      end
      SCAN: begin
        // A pixel on the closing startOfFrame cycle still belongs to this frame.
        if (digger_draw_req && gold_draw_req) ovl_d = 1'b1;
        if (dirt_draw_req && in_probe && (dirt_cnt_q < DIRT_SAT)) dirt_cnt_d = dirt_cnt_q + 6'd1;
`ifdef GOLD_PUSH_BLOCK_EN
        if (dirt_draw_req && in_side && (side_dirt_cnt_q < DIRT_SAT))
          side_dirt_cnt_d = side_dirt_cnt_q + 6'd1;
`endif
        if (startOfFrame) state_d = EVAL;
      end
      EVAL: begin
        push_cnt_d      = (approach && !push_fire && !push_block) ? push_inc : 2'd0;
        collision_d     = push_fire && !eaten_nxt;
        side_d          = digger_right;
        can_fall_d      = gs_rest && (dirt_cnt_q <= THRESH) && bottom_ok && !push_fire && !eaten_nxt;
        been_eaten_d    = eaten_nxt;
        digger_killed_d = ovl_q && gs_fall && !eaten_nxt;
        ovl_d           = 1'b0;
        dirt_cnt_d      = 6'd0;
`ifdef GOLD_PUSH_BLOCK_EN
        side_dirt_cnt_d = 6'd0;
`endif
        state_d         = SCAN;
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= WAIT_FRAME;
      ovl_q           <= 1'b0;
      dirt_cnt_q      <= 6'd0;
      push_cnt_q      <= 2'd0;
      collision_q     <= 1'b0;
      side_q          <= 1'b0;
      can_fall_q      <= 1'b0;
      been_eaten_q    <= 1'b0;
      digger_killed_q <= 1'b0;
`ifdef GOLD_PUSH_BLOCK_EN
      side_dirt_cnt_q <= 6'd0;
`endif
    end else begin
      state_q         <= state_d;
      ovl_q           <= ovl_d;
      dirt_cnt_q      <= dirt_cnt_d;
      push_cnt_q      <= push_cnt_d;
      collision_q     <= collision_d;
      side_q          <= side_d;
      can_fall_q      <= can_fall_d;
      been_eaten_q    <= been_eaten_d;
      digger_killed_q <= digger_killed_d;
`ifdef GOLD_PUSH_BLOCK_EN
      side_dirt_cnt_q <= side_dirt_cnt_d;
`endif
    end
  end

  assign collision     = collision_q;
  assign side          = side_q;
  assign can_fall      = can_fall_q;
  assign been_eaten    = been_eaten_q;
  assign digger_killed = digger_killed_q;

endmodule

// File: tb/tb_gold_interaction_ctrl.sv
// Frame-level bench: each frame's expected decisions are queued when its pixels are driven
// and popped once the DUT publishes them two cycles after the closing startOfFrame.
module tb_gold_interaction_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        digger_draw_req, gold_draw_req, dirt_draw_req;
  logic [10:0] digger_topLeftX, digger_topLeftY, gold_topLeftX, gold_topLeftY;
  logic [3:0]  gold_state;
  logic        collision, side, can_fall, been_eaten, digger_killed;

  gold_interaction_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .digger_draw_req (digger_draw_req),
    .gold_draw_req   (gold_draw_req),
    .dirt_draw_req   (dirt_draw_req),
    .digger_topLeftX (digger_topLeftX),
    .digger_topLeftY (digger_topLeftY),
    .gold_topLeftX   (gold_topLeftX),
    .gold_topLeftY   (gold_topLeftY),
    .gold_state      (gold_state),
    .collision       (collision),
    .side            (side),
    .can_fall        (can_fall),
    .been_eaten      (been_eaten),
    .digger_killed   (digger_killed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic col;
    logic sd;
    logic cf;
    logic eaten;
    logic kill;
  } exp_t;

  exp_t exp_q[$];
  exp_t prev_exp;
  int   checks = 0;
  int   errors = 0;
  int   m_push = 0;
  bit   m_eaten = 1'b0;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".collision"},     collision,     e.col);
    check({tag, ".side"},          side,          e.sd);
    check({tag, ".can_fall"},      can_fall,      e.cf);
    check({tag, ".been_eaten"},    been_eaten,    e.eaten);
    check({tag, ".digger_killed"}, digger_killed, e.kill);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input int x, input int y, input bit d, input bit g, input bit t);
    pixelX = 11'(x);
    pixelY = 11'(y);
    digger_draw_req = d;
    gold_draw_req   = g;
    dirt_draw_req   = t;
    cyc();
  endtask

  task automatic set_pos(input int dx, input int dy, input int gx, input int gy, input int gs);
    digger_topLeftX = 11'(dx);
    digger_topLeftY = 11'(dy);
    gold_topLeftX   = 11'(gx);
    gold_topLeftY   = 11'(gy);
    gold_state      = 4'(gs);
  endtask

  // One complete frame: pixels, closing startOfFrame, then the evaluation cycle.
  task automatic run_frame(input int dx, input int dy, input int gx, input int gy, input int gs,
                           input int n_ovl, input int n_dirt, input int n_side, input bit sof_ovl,
                           input string tag);
    exp_t e;
    bit   ovl, sd, appr, fire;
    int   dirt, dyd;
    ovl  = (n_ovl > 0) || sof_ovl;
    dirt = (n_dirt > 32) ? 32 : n_dirt;
    sd   = dx > gx;
    dyd  = (dy > gy) ? dy - gy : gy - dy;
    appr = ovl && (gs == 0) && (dyd < 16);
    if (appr) m_push = (m_push == 3) ? 3 : m_push + 1;
    else      m_push = 0;
    fire = appr && (m_push >= 2);
`ifdef GOLD_PUSH_BLOCK_EN
    if (sd && (n_side > 4)) begin
      fire   = 1'b0;
      m_push = 0;
    end
`endif
    if (fire) m_push = 0;
    m_eaten = m_eaten | (ovl && (gs == 2));
    e.col   = fire && !m_eaten;
    e.sd    = sd;
    e.cf    = (gs == 0) && (dirt <= 4) && (gy + 32 < 448) && !fire && !m_eaten;
    e.eaten = m_eaten;
    e.kill  = ovl && (gs == 1) && !m_eaten;
    exp_q.push_back(e);

    set_pos(dx, dy, gx, gy, gs);
    drive_px(gx + 1, gy + 1, 1'b1, 1'b0, 1'b0);
    drive_px(gx + 2, gy + 1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < n_ovl; k++) drive_px(gx + k, gy + 5, 1'b1, 1'b1, 1'b0);
    // Dirt just outside the probe row window must never count.
    drive_px(gx + 32, gy + 32, 1'b0, 1'b0, 1'b1);
    drive_px(gx - 1,  gy + 32, 1'b0, 1'b0, 1'b1);
    drive_px(gx + 5,  gy + 33, 1'b0, 1'b0, 1'b1);
    drive_px(gx + 5,  gy + 31, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < n_dirt; k++) drive_px(gx + (k % 32), gy + 32, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < n_side; k++) drive_px(gx - 1, gy + (k % 32), 1'b0, 1'b0, 1'b1);

    startOfFrame    = 1'b1;
    pixelX          = 11'(gx + 3);
    pixelY          = 11'(gy + 3);
    digger_draw_req = sof_ovl;
    gold_draw_req   = sof_ovl;
    dirt_draw_req   = 1'b0;
    cyc();
    startOfFrame    = 1'b0;
    digger_draw_req = 1'b0;
    gold_draw_req   = 1'b0;
    @(negedge clk);
    check_all({tag, "/hold"}, prev_exp);
    cyc();
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got none expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_all(tag, e);
      prev_exp = e;
    end
  endtask

  task automatic reset_mid(input int dx, input int gx, input int gy);
    set_pos(dx, gy, gx, gy, 0);
    for (int k = 0; k < 3; k++) drive_px(gx + k, gy + 5, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    check_all("rst_mid", '0);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) drive_px(gx + k, gy + 5, 1'b1, 1'b1, 1'b0);
    digger_draw_req = 1'b0;
    gold_draw_req   = 1'b0;
    startOfFrame    = 1'b1;
    cyc();
    startOfFrame    = 1'b0;
    m_push   = 0;
    m_eaten  = 1'b0;
    prev_exp = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    startOfFrame    = 1'b0;
    pixelX          = '0;
    pixelY          = '0;
    digger_draw_req = 1'b0;
    gold_draw_req   = 1'b0;
    dirt_draw_req   = 1'b0;
    set_pos(0, 0, 0, 0, 0);
    prev_exp        = '0;
    cyc();
    cyc();
    @(negedge clk);
    check_all("reset", '0);
    reset = 1'b0;
    cyc();
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;

    // Push from the right, then a held push re-firing every second frame.
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "push_r1");
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "push_r2");
    run_frame(90, 160, 64, 160, 0, 0, 32, 0, 1'b0, "push_r3");
    for (int f = 0; f < 4; f++) run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "held");
    run_frame(90, 160, 64, 160, 0, 0, 32, 0, 1'b0, "idle");

    // Left side, equal X, and vertical-approach boundaries.
    run_frame(40, 160, 64, 160, 0, 3, 32, 0, 1'b0, "left1");
    run_frame(40, 160, 64, 160, 0, 3, 32, 0, 1'b0, "left2");
    run_frame(64, 170, 64, 160, 0, 3, 32, 0, 1'b0, "eqx1");
    run_frame(64, 170, 64, 160, 0, 3, 32, 0, 1'b0, "eqx2");
    run_frame(64, 176, 64, 160, 0, 3, 32, 0, 1'b0, "dy16a");
    run_frame(64, 176, 64, 160, 0, 3, 32, 0, 1'b0, "dy16b");
    run_frame(64, 145, 64, 160, 0, 3, 32, 0, 1'b0, "dym15a");
    run_frame(64, 145, 64, 160, 0, 3, 32, 0, 1'b0, "dym15b");

    // Support probe and bottom edge.
    run_frame(200, 300, 64, 160, 0, 0, 3, 0, 1'b0, "fall3");
    run_frame(200, 300, 64, 160, 0, 0, 5, 0, 1'b0, "fall5");
    run_frame(200, 300, 64, 160, 0, 0, 4, 0, 1'b0, "fall4");
    run_frame(200, 300, 64, 416, 0, 0, 0, 0, 1'b0, "bottom416");
    run_frame(200, 300, 64, 415, 0, 0, 0, 0, 1'b0, "bottom415");
    run_frame(200, 300, -20, 1000, 0, 0, 0, 0, 1'b0, "farY");
    run_frame(200, 300, -40, -40, 0, 0, 2, 0, 1'b0, "negpos");

    // Push and fall qualifying together; pixel coincident with startOfFrame.
    run_frame(90, 160, 64, 160, 0, 4, 0, 0, 1'b0, "colfall1");
    run_frame(90, 160, 64, 160, 0, 4, 0, 0, 1'b0, "colfall2");
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "sofpix1");
    run_frame(90, 160, 64, 160, 0, 0, 32, 0, 1'b1, "sofpix2");

    // Side-column dirt: blocks only when the optional feature is built in.
    run_frame(90, 160, 64, 160, 0, 4, 32, 20, 1'b0, "block1");
    run_frame(90, 160, 64, 160, 0, 4, 32, 20, 1'b0, "block2");
    run_frame(90, 160, 64, 160, 0, 0, 32, 0, 1'b0, "idle2");

    // Crush, then eat and stickiness.
    run_frame(70, 180, 64, 160, 1, 4, 0, 0, 1'b0, "crush");
    run_frame(70, 180, 64, 160, 1, 0, 0, 0, 1'b0, "crush_off");
    run_frame(70, 170, 64, 160, 2, 4, 0, 0, 1'b0, "eat");
    for (int f = 0; f < 10; f++) run_frame(200, 300, 64, 160, 2, 0, 0, 0, 1'b0, "eaten_hold");
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "eaten_push1");
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "eaten_push2");
    run_frame(200, 300, 64, 160, 0, 0, 0, 0, 1'b0, "eaten_fall");
    run_frame(70, 180, 64, 160, 1, 4, 0, 0, 1'b0, "eaten_crush");

    // One overlap frame, mid-frame reset, then a push needs two fresh frames.
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "pre_rst");
    reset_mid(90, 64, 160);
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "post_rst1");
    run_frame(90, 160, 64, 160, 0, 4, 32, 0, 1'b0, "post_rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
